// File: rtl/iter_divider_if.sv
// Request/response bundle between the register-file side and the iterative divider.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;

  modport master (
    output start, is_signed, dividend, divisor,
    input  q, r, busy, done
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output q, r, busy, done
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up cycle.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  iter_divider_if.slave bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     rem_sh, diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Magnitudes: the most negative value maps to itself, read as unsigned.
    a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg = bus.is_signed & bus.divisor[WIDTH-1];
    a_abs = a_neg ? -bus.dividend : bus.dividend;
    b_abs = b_neg ? -bus.divisor  : bus.divisor;

    // Extra remainder bit keeps the borrow of the trial subtract.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = (bus.divisor == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Divide-by-zero leaves rem = |a|, so the sign fix restores the dividend.
        q_d     = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        r_d     = r_neg_q ? -rem_q : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: latency, sign handling, divide-by-zero,
// overflow, ignored/back-to-back starts and asynchronous abort.
module tb_iter_divider;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op, optionally injects a stray start at cycle inject_at, and
  // returns just after E33 (inside the done cycle).
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input int inject_at);
    int bad;
    bad = 0;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy@E0"}, W'(bus.busy), W'(1));
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k < 33) begin
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.q !== last_q || bus.r !== last_r)
          bad++;
        if (k == inject_at - 1) begin
          bus.start     = 1'b1;
          bus.is_signed = ~sgn;
          bus.dividend  = 32'h0000_0005;
          bus.divisor   = 32'h0000_0005;
        end
      end
    end
    check({tag, " calc_stable"}, W'(bad), W'(0));
    check({tag, " done@E33"}, W'(bus.done), W'(1));
    check({tag, " busy@E33"}, W'(bus.busy), W'(0));
    check({tag, " q"}, bus.q, exp_q);
    check({tag, " r"}, bus.r, exp_r);
    last_q = exp_q;
    last_r = exp_r;
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    check({tag, " done_drop"}, W'(bus.done), W'(0));
    check({tag, " busy_idle"}, W'(bus.busy), W'(0));
  endtask

  initial begin
    int seen_done;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    @(posedge clk); #1;
    check("reset q", bus.q, '0);
    check("reset r", bus.r, '0);
    check("reset busy", W'(bus.busy), W'(0));
    check("reset done", W'(bus.done), W'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1
    run_op("T1 u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    idle_after("T1");
    // T2
    run_op("T2 s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    idle_after("T2a");
    run_op("T2 s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
    idle_after("T2b");
    run_op("T2 s100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 0);
    idle_after("T2c");
    // T3
    run_op("T3 s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0);
    idle_after("T3a");
    run_op("T3 u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    idle_after("T3b");
    // T4
    run_op("T4 s/0", 1'b1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    idle_after("T4a");
    run_op("T4 u/0", 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    idle_after("T4b");
    run_op("T4 s-neg/0", 1'b1, 32'h8765_4321, 32'h0, 32'hFFFF_FFFF, 32'h8765_4321, 0);
    idle_after("T4c");
    // T5: stray start at cycle 10, then a start inside the done cycle
    run_op("T5 u1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 10);
    run_op("T5 chained", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 0);
    idle_after("T5");

    // T6: asynchronous reset in the middle of cycle 15
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd5000;
    bus.divisor   = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("T6 abort q", bus.q, '0);
    check("T6 abort r", bus.r, '0);
    check("T6 abort busy", W'(bus.busy), W'(0));
    check("T6 abort done", W'(bus.done), W'(0));
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
    end
    check("T6 no_done", W'(seen_done), W'(0));
    run_op("T6 s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
    idle_after("T6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
